// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared types and constants for the SimpleMIPS multiply/divide unit
package mdu_pkg;

   typedef enum logic [2:0] {
      OP_NONE  = 3'd0,
      OP_MULT  = 3'd1,
      OP_MULTU = 3'd2,
      OP_DIV   = 3'd3,
      OP_DIVU  = 3'd4,
      OP_MTHI  = 3'd5,
      OP_MTLO  = 3'd6
   } mdu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_FIX  = 2'd3
   } mdu_state_e;

   localparam int MDU_ITER = 32;

   function automatic logic [31:0] mag32(input logic [31:0] x, input logic is_signed);
      return (is_signed && x[31]) ? (32'd0 - x) : x;
   endfunction

endpackage

// File: rtl/mdu_divider.sv
// rtl/mdu_divider.sv - unsigned 32-step restoring divide core, one quotient bit per cycle
module mdu_divider
   import mdu_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        start_i,
   input  logic        flush_i,
   input  logic [31:0] dividend_i,
   input  logic [31:0] divisor_i,
   output logic        done_o,
   output logic [31:0] quot_o,
   output logic [31:0] rem_o
);

   logic        run_q, run_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [31:0] quot_q, quot_d;
   logic [31:0] rem_q, rem_d;
   logic [31:0] dsor_q, dsor_d;
   logic [32:0] partial;
   logic [31:0] sub;
   logic        ge;

   // quot_q doubles as the dividend shift register; its MSB feeds the partial remainder
   assign partial = {rem_q, quot_q[31]};
   assign ge      = partial >= {1'b0, dsor_q};
   assign sub     = partial[31:0] - dsor_q;

   always_comb begin
      run_d  = run_q;
      cnt_d  = cnt_q;
      quot_d = quot_q;
      rem_d  = rem_q;
      dsor_d = dsor_q;
      if (flush_i) begin
         run_d = 1'b0;
      end else if (start_i) begin
         run_d  = 1'b1;
         cnt_d  = 5'd0;
         quot_d = dividend_i;
         rem_d  = 32'd0;
         dsor_d = divisor_i;
      end else if (run_q) begin
         quot_d = {quot_q[30:0], ge};
         rem_d  = ge ? sub : partial[31:0];
         cnt_d  = cnt_q + 5'd1;
         if (cnt_q == 5'(MDU_ITER - 1)) run_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         run_q  <= 1'b0;
         cnt_q  <= 5'd0;
         quot_q <= 32'd0;
         rem_q  <= 32'd0;
         dsor_q <= 32'd0;
      end else begin
         run_q  <= run_d;
         cnt_q  <= cnt_d;
         quot_q <= quot_d;
         rem_q  <= rem_d;
         dsor_q <= dsor_d;
      end
   end

   assign done_o = run_q && (cnt_q == 5'(MDU_ITER - 1));
   assign quot_o = quot_q;
   assign rem_o  = rem_q;

endmodule

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative MULT/DIV unit with HI/LO; MDU_FAST_MUL_EN selects a single-cycle multiplier
module mul_div_unit
   import mdu_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        start_i,
   input  logic [2:0]  op_i,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  logic        cancel_i,
   output logic        busy_o,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o
);

   mdu_state_e  state_q, state_d;
   logic [31:0] hi_q, hi_d, lo_q, lo_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        neg_q, neg_d, rneg_q, rneg_d, dz_q, dz_d;
   logic        op_signed, issue, div_start, div_done;
   logic [31:0] a_mag, b_mag, div_quot, div_rem;
`ifdef MDU_FAST_MUL_EN
   logic [63:0] ext_a, ext_b, fast_prod;
`else
   logic        is_div_q, is_div_d;
   logic [63:0] prod_q, prod_d;
   logic [31:0] mcand_q, mcand_d;
   logic [32:0] mul_sum;
`endif

   assign op_signed = (op_i == OP_MULT) || (op_i == OP_DIV);
   assign a_mag     = mag32(a_i, op_signed);
   assign b_mag     = mag32(b_i, op_signed);
   assign issue     = (state_q == ST_IDLE) && start_i && !cancel_i && (op_i != OP_NONE);
   assign div_start = issue && ((op_i == OP_DIV) || (op_i == OP_DIVU));

`ifdef MDU_FAST_MUL_EN
   // low 64 bits of the extended product are correct for both signed and unsigned
   assign ext_a     = {{32{op_signed & a_i[31]}}, a_i};
   assign ext_b     = {{32{op_signed & b_i[31]}}, b_i};
   assign fast_prod = ext_a * ext_b;
`else
   // product low half starts as the multiplier and is consumed LSB-first
   assign mul_sum   = {1'b0, prod_q[63:32]} + (prod_q[0] ? {1'b0, mcand_q} : 33'd0);
`endif

   mdu_divider u_divider (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .start_i    (div_start),
      .flush_i    (cancel_i),
      .dividend_i (a_mag),
      .divisor_i  (b_mag),
      .done_o     (div_done),
      .quot_o     (div_quot),
      .rem_o      (div_rem)
   );

   always_comb begin
      state_d  = state_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      cnt_d    = cnt_q;
      neg_d    = neg_q;
      rneg_d   = rneg_q;
      dz_d     = dz_q;
`ifndef MDU_FAST_MUL_EN
      is_div_d = is_div_q;
      prod_d   = prod_q;
      mcand_d  = mcand_q;
`endif
      if (state_q != ST_IDLE && cancel_i) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: if (issue) begin
               neg_d  = op_signed & (a_i[31] ^ b_i[31]);
               rneg_d = op_signed & a_i[31];
               case (op_i)
                  OP_MTHI: hi_d = a_i;
                  OP_MTLO: lo_d = a_i;
                  OP_MULT, OP_MULTU: begin
`ifdef MDU_FAST_MUL_EN
                     {hi_d, lo_d} = fast_prod;
`else
                     state_d  = ST_MUL;
                     is_div_d = 1'b0;
                     mcand_d  = a_mag;
                     prod_d   = {32'd0, b_mag};
                     cnt_d    = 5'd0;
`endif
                  end
                  OP_DIV, OP_DIVU: begin
                     state_d  = ST_DIV;
`ifndef MDU_FAST_MUL_EN
                     is_div_d = 1'b1;
`endif
                     dz_d     = (b_i == 32'd0);
                  end
                  default: ;
               endcase
            end
`ifndef MDU_FAST_MUL_EN
            ST_MUL: begin
               prod_d = {mul_sum, prod_q[31:1]};
               cnt_d  = cnt_q + 5'd1;
               if (cnt_q == 5'(MDU_ITER - 1)) state_d = ST_FIX;
            end
`endif
            ST_DIV: if (div_done) state_d = ST_FIX;
            ST_FIX: begin
               state_d = ST_IDLE;
`ifndef MDU_FAST_MUL_EN
               if (!is_div_q) begin
                  {hi_d, lo_d} = neg_q ? (64'd0 - prod_q) : prod_q;
               end else
`endif
               begin
                  // a zero divisor leaves the dividend magnitude in the remainder, so HI restores a_i
                  lo_d = dz_q ? 32'hFFFF_FFFF : (neg_q ? (32'd0 - div_quot) : div_quot);
                  hi_d = rneg_q ? (32'd0 - div_rem) : div_rem;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= ST_IDLE;
         hi_q     <= 32'd0;
         lo_q     <= 32'd0;
         cnt_q    <= 5'd0;
         neg_q    <= 1'b0;
         rneg_q   <= 1'b0;
         dz_q     <= 1'b0;
`ifndef MDU_FAST_MUL_EN
         is_div_q <= 1'b0;
         prod_q   <= 64'd0;
         mcand_q  <= 32'd0;
`endif
      end else begin
         state_q  <= state_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         cnt_q    <= cnt_d;
         neg_q    <= neg_d;
         rneg_q   <= rneg_d;
         dz_q     <= dz_d;
`ifndef MDU_FAST_MUL_EN
         is_div_q <= is_div_d;
         prod_q   <= prod_d;
         mcand_q  <= mcand_d;
`endif
      end
   end

   assign busy_o = (state_q != ST_IDLE);
   assign hi_o   = hi_q;
   assign lo_o   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - directed self-checking bench for mul_div_unit
module tb_mul_div_unit;
   import mdu_pkg::*;

`ifdef MDU_FAST_MUL_EN
   localparam int MUL_LAT = 0;
`else
   localparam int MUL_LAT = 33;
`endif
   localparam int DIV_LAT = 33;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        start_i;
   logic [2:0]  op_i;
   logic [31:0] a_i, b_i;
   logic        cancel_i;
   logic        busy_o;
   logic [31:0] hi_o, lo_o;

   int tests = 0;
   int fails = 0;

   mul_div_unit dut (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .start_i  (start_i),
      .op_i     (op_i),
      .a_i      (a_i),
      .b_i      (b_i),
      .cancel_i (cancel_i),
      .busy_o   (busy_o),
      .hi_o     (hi_o),
      .lo_o     (lo_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // called just after a falling edge; issues in this cycle and counts busy cycles afterwards
   task automatic run_op(input string tag, input mdu_op_e op, input logic [31:0] a,
                         input logic [31:0] b, input int exp_lat,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      int n;
      start_i = 1'b1; op_i = op; a_i = a; b_i = b;
      @(negedge clk_i);
      start_i = 1'b0; op_i = OP_NONE;
      n = 0;
      while (busy_o && n < 100) begin
         n++;
         @(negedge clk_i);
      end
      check({tag, " latency"}, 64'(n), 64'(exp_lat));
      check({tag, " hi"}, {32'd0, hi_o}, {32'd0, exp_hi});
      check({tag, " lo"}, {32'd0, lo_o}, {32'd0, exp_lo});
   endtask

   initial begin
      int n;
      rst_ni = 1'b0; start_i = 1'b0; op_i = OP_NONE; a_i = '0; b_i = '0; cancel_i = 1'b0;
      repeat (2) @(negedge clk_i);
      check("reset hi", {32'd0, hi_o}, 64'd0);
      check("reset lo", {32'd0, lo_o}, 64'd0);
      check("reset busy", {63'd0, busy_o}, 64'd0);
      rst_ni = 1'b1;
      @(negedge clk_i);

      run_op("mthi", OP_MTHI, 32'h1234_5678, 32'd0, 0, 32'h1234_5678, 32'h0000_0000);
      run_op("mtlo", OP_MTLO, 32'hCAFE_F00D, 32'd0, 0, 32'h1234_5678, 32'hCAFE_F00D);

      run_op("mult -3x7", OP_MULT, 32'hFFFF_FFFD, 32'd7, MUL_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
      run_op("multu ffffffffx2", OP_MULTU, 32'hFFFF_FFFF, 32'd2, MUL_LAT, 32'h0000_0001, 32'hFFFF_FFFE);
      run_op("mult minxmin", OP_MULT, 32'h8000_0000, 32'h8000_0000, MUL_LAT, 32'h4000_0000, 32'h0000_0000);
      run_op("mult -1x-1", OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT, 32'h0000_0000, 32'h0000_0001);
      run_op("multu ffffffff^2", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT, 32'hFFFF_FFFE, 32'h0000_0001);

      run_op("div -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, DIV_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_op("divu 100/7", OP_DIVU, 32'd100, 32'd7, DIV_LAT, 32'd2, 32'd14);
      run_op("div 7/-2", OP_DIV, 32'd7, 32'hFFFF_FFFE, DIV_LAT, 32'd1, 32'hFFFF_FFFD);
      run_op("divu 5/0", OP_DIVU, 32'd5, 32'd0, DIV_LAT, 32'd5, 32'hFFFF_FFFF);
      run_op("div -5/0", OP_DIV, 32'hFFFF_FFFB, 32'd0, DIV_LAT, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
      run_op("div min/-1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, DIV_LAT, 32'h0000_0000, 32'h8000_0000);
      run_op("divu big", OP_DIVU, 32'hFFFF_FFFF, 32'h0001_0000, DIV_LAT, 32'h0000_FFFF, 32'h0000_FFFF);

      // cancel in cycle t+10 of a divide; HI/LO keep 0000ffff/0000ffff
      start_i = 1'b1; op_i = OP_DIV; a_i = 32'd100; b_i = 32'd7;
      @(negedge clk_i);
      start_i = 1'b0; op_i = OP_NONE;
      n = 0;
      while (busy_o && n < 100) begin
         cancel_i = (n == 9);
         n++;
         @(negedge clk_i);
      end
      cancel_i = 1'b0;
      check("cancel busy cycles", 64'(n), 64'd10);
      repeat (40) @(negedge clk_i);
      check("cancel hi kept", {32'd0, hi_o}, 64'h0000_FFFF);
      check("cancel lo kept", {32'd0, lo_o}, 64'h0000_FFFF);
      check("cancel busy idle", {63'd0, busy_o}, 64'd0);

      // start pulsed while busy must not disturb the running divide
      start_i = 1'b1; op_i = OP_DIVU; a_i = 32'd100; b_i = 32'd7;
      @(negedge clk_i);
      start_i = 1'b0; op_i = OP_NONE;
      n = 0;
      while (busy_o && n < 100) begin
         start_i = (n == 4);
         op_i    = (n == 4) ? OP_MTHI : OP_NONE;
         a_i     = 32'hDEAD_BEEF;
         n++;
         @(negedge clk_i);
      end
      start_i = 1'b0; op_i = OP_NONE;
      check("busy-start latency", 64'(n), 64'd33);
      check("busy-start hi", {32'd0, hi_o}, 64'd2);
      check("busy-start lo", {32'd0, lo_o}, 64'd14);

      // cancel together with start in IDLE drops the MTLO
      start_i = 1'b1; op_i = OP_MTLO; a_i = 32'h5555_AAAA; cancel_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0; op_i = OP_NONE; cancel_i = 1'b0;
      check("cancel+start lo", {32'd0, lo_o}, 64'd14);
      check("cancel+start busy", {63'd0, busy_o}, 64'd0);

      // asynchronous reset in the middle of a multiply
      start_i = 1'b1; op_i = OP_MULTU; a_i = 32'd9; b_i = 32'd9;
      @(negedge clk_i);
      start_i = 1'b0; op_i = OP_NONE;
      repeat (4) @(negedge clk_i);
      #2 rst_ni = 1'b0;
      #1;
      check("async rst hi", {32'd0, hi_o}, 64'd0);
      check("async rst lo", {32'd0, lo_o}, 64'd0);
      check("async rst busy", {63'd0, busy_o}, 64'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);
      run_op("post-rst multu", OP_MULTU, 32'd9, 32'd9, MUL_LAT, 32'd0, 32'd81);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative multiply/divide unit with architectural HI/LO registers for the SimpleMIPS execute stage. It sits directly downstream of the EX operand-forwarding multiplexers and sign-extension logic and consumes the same rs/rt operands as the ALU. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO, and provides HI/LO to MFHI/MFLO. While a long operation runs it raises a stall request to the hazard unit.

## Interface
- No parameters. Width is fixed at 32 bits.
- clk_i  in  1  system clock; all state updates on the rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- start_i  in  1  issue request for op_i; sampled only in IDLE
- op_i  in  3  mdu_op_e: NONE, MULT, MULTU, DIV, DIVU, MTHI, MTLO
- a_i  in  32  rs operand (dividend / multiplicand / MTxx source)
- b_i  in  32  rt operand (divisor / multiplier)
- cancel_i  in  1  exception flush; aborts the in-flight operation
- busy_o  out  1  stall request; high while a multi-cycle operation runs
- hi_o  out  32  architectural HI register
- lo_o  out  32  architectural LO register

## Operation
- Reset: state IDLE; hi_o=0, lo_o=0, busy_o=0, counter=0.
- FSM states: IDLE, MUL, DIV, FIX.
  - IDLE: accepts start_i when op_i≠NONE.
  - MTHI/MTLO: writes a_i into HI/LO at that edge and stays in IDLE.
  - MULT/MULTU: registers |a|, |b| for signed, raw for unsigned, plus the result sign; goes to MUL. Under MDU_FAST_MUL_EN it writes the result directly and stays in IDLE.
  - DIV/DIVU: goes to DIV with the same operand capture, plus the quotient and remainder signs.
  - MUL: radix-2 shift-add, one multiplier bit per cycle, 32 cycles; then FIX.
  - DIV: restoring shift-subtract, one quotient bit per cycle, 32 cycles; then FIX.
  - FIX: applies two's-complement sign correction and writes HI/LO; then IDLE.
- Results:
  - Multiply: {HI,LO} = full 64-bit product.
  - Divide: LO = quotient, truncated toward zero; HI = remainder, which carries the dividend's sign.
- Divide by zero: LO=32'hFFFF_FFFF, HI=a_i. This applies to both signed and unsigned divides, holds regardless of operand signs, and takes the full latency.
- Signed 32'h8000_0000 / -1: LO=32'h8000_0000, HI=0. Natural result of the datapath; no special case.
- start_i outside IDLE is ignored. The hazard unit does not issue while busy_o is high.
- cancel_i in MUL/DIV/FIX: returns to IDLE at the next edge; HI/LO unchanged.
- cancel_i together with start_i in IDLE: the start is dropped, including MTHI/MTLO.
- Asynchronous reset mid-operation: immediate return to reset values.
- Only HI/LO writes are visible; intermediate values stay internal.

## Timing
- Start accepted at the edge ending cycle t.
- Iterative MULT/DIV:
  - busy_o=1 in cycles t+1..t+33 (32 iterate cycles plus FIX).
  - HI/LO updated at the edge ending t+33, visible in t+34.
  - busy_o=0 in t+34.
- MTHI/MTLO: visible in t+1; busy_o never asserted.
- Fast multiply (macro on): HI/LO visible in t+1; busy_o never asserted.
- busy_o is a registered state decode (state≠IDLE). No combinational path from inputs.
- hi_o/lo_o are driven directly from registers.
- Back-to-back issue is allowed in the cycle busy_o falls.

## Configuration
- MDU_FAST_MUL_EN defined: MULT/MULTU use a single-cycle 64-bit multiplier (signed or unsigned `*`) written at the issue edge; the MUL state is not generated. DIV is unchanged.
- Undefined: iterative 33-cycle multiply as described; no hardware multiplier is inferred.

## Structure
- mdu_pkg: mdu_op_e enum (3-bit), mdu_state_e, MDU_ITER=32 constant.
- Sub-module mdu_divider: 32-step restoring divide core with start/done. Its done pulse drives the transition to FIX; it has no sign handling.
- The shift-add multiplier and sign fix remain in the top level.

## Test plan
- Reset → hi_o=0, lo_o=0, busy_o=0; MTHI 32'h1234_5678 → hi_o=32'h1234_5678 next cycle, busy_o stays 0.
- MULT a=-3, b=7 → busy_o high for 33 cycles; HI=32'hFFFF_FFFF, LO=32'hFFFF_FFEB. MULTU of 32'hFFFF_FFFF×2 → HI=1, LO=32'hFFFF_FFFE.
- DIV a=-7, b=2 → LO=32'hFFFF_FFFD (-3), HI=32'hFFFF_FFFF (-1). DIVU 100/7 → LO=14, HI=2.
- DIVU 5/0 → LO=32'hFFFF_FFFF, HI=5. DIV 32'h8000_0000/-1 → LO=32'h8000_0000, HI=0.
- Start DIV, assert cancel_i in cycle t+10 → busy_o=0 next cycle; HI/LO keep prior values. start_i pulsed while busy → no effect on the result.
- Build with MDU_FAST_MUL_EN: MULT -3×7 gives the same values as above, visible in t+1 with busy_o never high; DIV latency unchanged at 33 cycles.
